// File: rtl/ram_stream_pkg.sv
// Shared sizing constants and types for the RAM-backed byte stream controller.
package ram_stream_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = ADDR_W + 1;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/ram_stream_ctrl.sv
// Stream controller that buffers bytes in an external 16x8 RAM: writes through
// port 0, reads back in FIFO order through port 1 into a registered output.
module ram_stream_ctrl #(
    parameter int DATA_W = ram_stream_pkg::DATA_W,
    parameter int ADDR_W = ram_stream_pkg::ADDR_W,
    parameter int DEPTH  = ram_stream_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W:0]   count,
    output logic              ram_port_en_0,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_addr_0,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              ram_port_en_1,
    output logic [ADDR_W-1:0] ram_addr_1,
    input  logic [DATA_W-1:0] ram_rd_data
);

    localparam int CNT_W = ADDR_W + 1;

    logic [ADDR_W-1:0] r_wrPtr;
    logic [ADDR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0]  r_count;
    logic              r_outValid;
    logic [DATA_W-1:0] r_outData;

    logic              w_notEmpty;
    logic              w_push;
    logic              w_load;
    logic [CNT_W-1:0]  w_countNext;

    // Readiness depends only on rst, flush and the registered count, so a
    // slot freed by a load at full is only offered on the following cycle.
    assign in_ready    = !rst && !flush && (r_count != CNT_W'(DEPTH));
    assign w_push      = in_valid && in_ready;
    assign w_notEmpty  = (r_count != '0);
    assign w_load      = w_notEmpty && (!r_outValid || out_ready) && !flush;
    assign w_countNext = r_count + {{ADDR_W{1'b0}}, w_push}
                                 - {{ADDR_W{1'b0}}, w_load};

    assign ram_port_en_0 = w_push;
    assign ram_wr_en     = w_push;
    assign ram_addr_0    = r_wrPtr;
    assign ram_wr_data   = in_data;
    assign ram_port_en_1 = w_notEmpty;
    assign ram_addr_1    = r_rdPtr;

    assign count     = r_count;
    assign out_valid = r_outValid;
    assign out_data  = r_outData;

    // Flush clears the buffer but leaves the last output byte in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_outValid <= 1'b0;
            r_outData  <= '0;
        end else if (flush) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_outValid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + ADDR_W'(1);
            end
            if (w_load) begin
                r_outData  <= ram_rd_data;
                r_outValid <= 1'b1;
                r_rdPtr    <= r_rdPtr + ADDR_W'(1);
            end else if (r_outValid && out_ready) begin
                r_outValid <= 1'b0;
            end
            r_count <= w_countNext;
        end
    end

endmodule

// File: tb/tb_ram_stream_ctrl.sv
// Randomized bench for ram_stream_ctrl with a behavioural RAM and a queue-based
// reference model of the buffered byte stream.
module tb_ram_stream_ctrl;
    import ram_stream_pkg::*;

    logic  clk = 1'b0;
    logic  rst, flush, inValid, outReady;
    data_t inData;
    logic  inReady, outValid;
    data_t outData;
    cnt_t  count;
    logic  ramPortEn0, ramWrEn, ramPortEn1;
    addr_t ramAddr0, ramAddr1;
    data_t ramWrData, ramRdData;

    data_t mem [DEPTH];

    int checkCount = 0;
    int errorCount = 0;

    data_t modelQ[$];
    logic  modelValid;
    data_t modelData;

    always #5 clk = ~clk;

    ram_stream_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(inValid), .in_ready(inReady), .in_data(inData),
        .out_valid(outValid), .out_ready(outReady), .out_data(outData),
        .count(count),
        .ram_port_en_0(ramPortEn0), .ram_wr_en(ramWrEn),
        .ram_addr_0(ramAddr0), .ram_wr_data(ramWrData),
        .ram_port_en_1(ramPortEn1), .ram_addr_1(ramAddr1),
        .ram_rd_data(ramRdData)
    );

    // Behavioural 16x8 RAM: synchronous write on port 0, async read on port 1.
    always @(posedge clk) begin
        if (ramPortEn0 && ramWrEn) mem[ramAddr0] <= ramWrData;
    end
    assign ramRdData = mem[ramAddr1];

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs against the
    // model, advance the model across the edge, then check registered outputs.
    task automatic applyStimulus(input logic iRst, input logic iFlush, input logic iValid,
                                 input data_t iData, input logic iReady, output logic accepted);
        logic expReady, expPush, expLoad;
        rst = iRst; flush = iFlush; inValid = iValid; inData = iData; outReady = iReady;
        #1;
        expReady = !iRst && !iFlush && (modelQ.size() != DEPTH);
        expPush  = iValid && expReady;
        expLoad  = !iRst && !iFlush && (modelQ.size() != 0) && (!modelValid || iReady);
        checkOutput("in_ready", int'(inReady), int'(expReady));
        checkOutput("ram_wr_en", int'(ramWrEn), int'(expPush));
        checkOutput("ram_port_en_1", int'(ramPortEn1), int'(!iRst && modelQ.size() != 0 || iRst && ramPortEn1));
        if (expPush) checkOutput("ram_wr_data", int'(ramWrData), int'(iData));
        @(posedge clk);
        if (iRst) begin
            modelQ.delete(); modelValid = 1'b0; modelData = '0;
        end else if (iFlush) begin
            modelQ.delete(); modelValid = 1'b0;
        end else begin
            if (expLoad) begin
                modelData  = modelQ.pop_front();
                modelValid = 1'b1;
            end else if (modelValid && iReady) begin
                modelValid = 1'b0;
            end
            if (expPush) modelQ.push_back(iData);
        end
        #1;
        checkOutput("count", int'(count), modelQ.size());
        checkOutput("out_valid", int'(outValid), int'(modelValid));
        checkOutput("out_data", int'(outData), int'(modelData));
        accepted = expPush;
    endtask

    task automatic pushByte(input data_t b, input logic iReady);
        logic acc;
        int   budget = 60;
        acc = 1'b0;
        while (!acc && budget > 0) begin
            applyStimulus(1'b0, 1'b0, 1'b1, b, iReady, acc);
            budget--;
        end
        if (!acc) checkOutput("push_timeout", 0, 1);
    endtask

    task automatic idle(input int n, input logic iReady);
        logic acc;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, iReady, acc);
    endtask

    initial begin
        logic acc;
        int   sent;
        int   budget;
        modelValid = 1'b0; modelData = '0;
        rst = 1'b1; flush = 1'b0; inValid = 1'b0; inData = '0; outReady = 1'b0;

        // Reset state
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, acc);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, acc);
        idle(1, 1'b0);

        // Reset mid-stream discards data; 0x5A becomes the first output
        pushByte(8'h01, 1'b0); pushByte(8'h02, 1'b0); pushByte(8'h03, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, acc);
        checkOutput("rst_mid_count", int'(count), 0);
        pushByte(8'h5A, 1'b1);
        idle(1, 1'b0);
        checkOutput("rst_mid_first", int'(outData), 8'h5A);
        idle(2, 1'b1);

        // Basic order and latency with out_ready held high
        pushByte(8'h11, 1'b1);
        checkOutput("latency_n", int'(outValid), 0);
        pushByte(8'h22, 1'b1);
        checkOutput("latency_n1", int'(outValid), 1);
        pushByte(8'h33, 1'b1);
        idle(4, 1'b1);

        // Full: 17 bytes with the consumer stalled, then drain
        for (int i = 0; i <= 16; i++) pushByte(data_t'(i), 1'b0);
        checkOutput("full_count", int'(count), 16);
        checkOutput("full_ready", int'(inReady), 0);
        idle(20, 1'b1);

        // Load at full frees a slot; in_ready rises a cycle later
        for (int i = 0; i <= 16; i++) pushByte(data_t'(8'h40 + i), 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hEE, 1'b1, acc);
        checkOutput("full_load_noaccept", int'(acc), 0);
        checkOutput("full_load_count", int'(count), 15);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hEE, 1'b1, acc);
        checkOutput("full_after_accept", int'(acc), 1);
        idle(20, 1'b1);

        // Wrap-around with random consumer backpressure
        sent = 0; budget = 600;
        while (sent < 40 && budget > 0) begin
            applyStimulus(1'b0, 1'b0, 1'b1, data_t'($urandom), logic'($urandom_range(0, 1)), acc);
            if (acc) sent++;
            budget--;
        end
        checkOutput("wrap_sent", sent, 40);
        idle(20, 1'b1);

        // Flush with count = 5 and out_valid = 1
        for (int i = 0; i < 6; i++) pushByte(data_t'(8'h70 + i), 1'b0);
        checkOutput("pre_flush_count", int'(count), 5);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'hCC, 1'b1, acc);
        checkOutput("flush_noaccept", int'(acc), 0);
        pushByte(8'hA5, 1'b0);
        idle(1, 1'b0);
        checkOutput("flush_next", int'(outData), 8'hA5);
        idle(2, 1'b1);

        // Random soak including occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            applyStimulus(logic'($urandom_range(0, 99) == 0), logic'($urandom_range(0, 29) == 0),
                          logic'($urandom_range(0, 1)), data_t'($urandom),
                          logic'($urandom_range(0, 2) != 0), acc);
        end
        idle(20, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
